// File: rtl/fifo_write_packer.sv
// rtl/fifo_write_packer.sv - packs a byte stream little-endian into FIFO words with in_last flush.
// Optional FIFO_WRITE_PACKER_WORD_COUNT_EN adds the word_count output.
module fifo_write_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 8,
  parameter int LANES      = DATA_WIDTH / IN_WIDTH,
  parameter int LANE_BITS  = (LANES > 1) ? $clog2(LANES) : 1,
  parameter int COUNT_BITS = 16
) (
  input  logic                  write_clock,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  write_enable,
  output logic                  partial
`ifdef FIFO_WRITE_PACKER_WORD_COUNT_EN
  ,
  output logic [COUNT_BITS-1:0] word_count
`endif
);

  typedef enum logic {S_FILL, S_STALL} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_word;
  logic [LANE_BITS-1:0]  r_lane;
  logic                  r_pending;
  logic                  r_partial;
  logic                  r_acc_partial;
  logic                  w_last_lane;
  logic                  w_out_free;
  logic                  w_xfer;
  logic                  w_complete;

  assign w_last_lane  = (r_lane == LANE_BITS'(LANES - 1));
  assign write_enable = r_pending && !fifo_full;
  assign w_out_free   = !r_pending || write_enable;
  assign w_xfer       = in_valid && in_ready;
  assign w_complete   = w_xfer && (w_last_lane || in_last);
  assign data         = r_data;
  assign partial      = r_partial;

  // Lane 0 starts from zero so lanes above the current one are always zero-filled.
  always_comb begin
    w_word = (r_lane == '0) ? '0 : r_acc;
    w_word[r_lane*IN_WIDTH +: IN_WIDTH] = in_data;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      S_FILL: begin
        in_ready = 1'b1;
        if (w_complete && !w_out_free) w_state_next = S_STALL;
      end
      S_STALL: begin
        if (w_out_free) w_state_next = S_FILL;
      end
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge write_clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_FILL;
      r_acc         <= '0;
      r_data        <= '0;
      r_lane        <= '0;
      r_pending     <= 1'b0;
      r_partial     <= 1'b0;
      r_acc_partial <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (write_enable) r_pending <= 1'b0;
      if (r_state == S_STALL) begin
        if (w_out_free) begin
          r_data    <= r_acc;
          r_partial <= r_acc_partial;
          r_pending <= 1'b1;
          r_lane    <= '0;
        end
      end else if (w_complete) begin
        r_lane <= '0;
        if (w_out_free) begin
          r_data    <= w_word;
          r_partial <= !w_last_lane;
          r_pending <= 1'b1;
        end else begin
          r_acc         <= w_word;
          r_acc_partial <= !w_last_lane;
        end
      end else if (w_xfer) begin
        r_acc  <= w_word;
        r_lane <= r_lane + 1'b1;
      end
    end
  end

`ifdef FIFO_WRITE_PACKER_WORD_COUNT_EN
  logic [COUNT_BITS-1:0] r_word_count;

  always_ff @(posedge write_clock or posedge reset) begin
    if (reset) r_word_count <= '0;
    else if (write_enable) r_word_count <= r_word_count + 1'b1;
  end

  assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_fifo_write_packer.sv
// tb/tb_fifo_write_packer.sv - randomized bench for fifo_write_packer with a queue-based word model.
`timescale 1ns/1ps
module tb_fifo_write_packer;
  localparam int LN = 4;

  logic        write_clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        fifo_full = 1'b0;
  logic [31:0] data;
  logic        write_enable;
  logic        partial;
`ifdef FIFO_WRITE_PACKER_WORD_COUNT_EN
  logic [15:0] word_count;
`endif

  fifo_write_packer dut (
    .write_clock (write_clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .fifo_full   (fifo_full),
    .data        (data),
    .write_enable(write_enable),
    .partial     (partial)
`ifdef FIFO_WRITE_PACKER_WORD_COUNT_EN
    ,
    .word_count  (word_count)
`endif
  );

  always #5 write_clock = ~write_clock;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_writes = 0;
  int          outstanding = 0;
  bit          rand_full = 1'b0;
  logic [7:0]  byte_q[$];
  logic [32:0] exp_q[$];
  int          wr_cyc[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge write_clock) cyc++;

  // Reference: words are formed from accepted bytes; the packer can hold at most two finished words.
  always @(negedge write_clock) begin
    if (!reset) begin
      logic [32:0] e;
      check_val("in_ready", in_ready, outstanding < 2);
      if (write_enable && fifo_full) check_val("we_while_full", 1, 0);
      if (write_enable) begin
        wr_cyc.push_back(cyc);
        n_writes++;
        if (exp_q.size() == 0) begin
          check_val("spurious_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("data", data, e[31:0]);
          check_val("partial", partial, e[32]);
          outstanding--;
        end
      end
      if (in_valid && in_ready) begin
        byte_q.push_back(in_data);
        if (in_last || byte_q.size() == LN) begin
          e = '0;
          foreach (byte_q[k]) e[k*8 +: 8] = byte_q[k];
          e[32] = (byte_q.size() < LN);
          exp_q.push_back(e);
          byte_q.delete();
          outstanding++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge write_clock);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    bit done = 1'b0;
    in_data  = b;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge write_clock);
      done = in_ready;
      tick();
      if (rand_full) fifo_full = ($urandom_range(0, 2) == 0);
    end
    if (!done) check_val("send_timeout", 0, 1);
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    byte_q.delete();
    exp_q.delete();
    outstanding = 0;
    n_writes    = 0;
    @(negedge write_clock);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_we", write_enable, 0);
    check_val("rst_data", data, 0);
    check_val("rst_partial", partial, 0);
`ifdef FIFO_WRITE_PACKER_WORD_COUNT_EN
    check_val("rst_word_count", word_count, 0);
`endif
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut();

    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    in_valid = 1'b0;
    @(negedge write_clock);
    check_val("t1_we", write_enable, 1);
    check_val("t1_data", data, 32'h44332211);
    check_val("t1_partial", partial, 0);
    tick();

    send(8'hAA, 0); send(8'hBB, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge write_clock);
    check_val("t2_we", write_enable, 1);
    check_val("t2_data", data, 32'h0000BBAA);
    check_val("t2_partial", partial, 1);
    tick();
    for (int i = 0; i < 4; i++) send(8'($urandom), 0);
    idle(3);

    fifo_full = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    idle(3);
    check_val("t3_stall_ready", in_ready, 0);
    check_val("t3_full_we", write_enable, 0);
    fifo_full = 1'b0;
    @(negedge write_clock);
    check_val("t3_we1", write_enable, 1);
    check_val("t3_data1", data, 32'h04030201);
    tick();
    @(negedge write_clock);
    check_val("t3_we2", write_enable, 1);
    check_val("t3_data2", data, 32'h08070605);
    check_val("t3_ready_back", in_ready, 1);
    tick();
    idle(2);

    wr_cyc.delete();
    for (int i = 0; i < 16; i++) send(8'($urandom), 0);
    idle(3);
    check_val("t4_writes", wr_cyc.size(), 4);
    for (int i = 1; i < wr_cyc.size(); i++) check_val("t4_spacing", wr_cyc[i] - wr_cyc[i-1], 4);

    fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) send(8'($urandom), 0);
    in_valid = 1'b0;
    reset_dut();
    fifo_full = 1'b0;
    send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
    in_valid = 1'b0;
    @(negedge write_clock);
    check_val("t5_data", data, 32'hC4C3C2C1);
    check_val("t5_we", write_enable, 1);
    tick();
    idle(2);

    rand_full = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(8'($urandom), $urandom_range(0, 5) == 0);
    end
    rand_full = 1'b0;
    fifo_full = 1'b0;
    idle(6);
    check_val("drain_queue", exp_q.size(), 0);
    check_val("drain_outstanding", outstanding, 0);
`ifdef FIFO_WRITE_PACKER_WORD_COUNT_EN
    check_val("word_count", word_count, n_writes[15:0]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
